// File: rtl/bitstream_block_assembler.sv
// Serial (run, coefficient) parser that assembles TABLE_SIZE-entry coefficient blocks.
// Optional DC prediction on entry 0: define ASSEMBLER_DC_PREDICTION_EN. Serial input is stream_bit ("bit" is reserved).
module bitstream_block_assembler #(
  parameter int RUN_WIDTH               = 4,
  parameter int COEF_WIDTH              = 8,
  parameter int TABLE_SIZE              = 64,
  parameter int BLOCK_WIDTH_SIZE        = 40,
  parameter int BLOCK_HEIGHT_SIZE       = 30,
  parameter int BLOCK_WIDTH_INDEX_SIZE  = $clog2(BLOCK_WIDTH_SIZE),
  parameter int BLOCK_HEIGHT_INDEX_SIZE = $clog2(BLOCK_HEIGHT_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stream_bit,
  input  logic                               is_new,
  output logic                               bit_ready,
  output logic [TABLE_SIZE*COEF_WIDTH-1:0]   table_value,
  output logic                               table_valid,
  input  logic                               table_ready,
  output logic [BLOCK_WIDTH_INDEX_SIZE-1:0]  block_col,
  output logic [BLOCK_HEIGHT_INDEX_SIZE-1:0] block_row,
  output logic                               frame_done,
  output logic                               overflow_error
);
  localparam int POS_W = $clog2(TABLE_SIZE) + 1;
  localparam int TGT_W = POS_W + 1;
  localparam int CNT_W = $clog2(RUN_WIDTH > COEF_WIDTH ? RUN_WIDTH : COEF_WIDTH) + 1;

  typedef enum logic [1:0] {S_RUN, S_COEF, S_HOLD} state_t;

  state_t                        state_reg, state_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [POS_W-1:0]              pos_reg, pos_next;
  logic [RUN_WIDTH-1:0]          run_reg;
  logic [COEF_WIDTH-1:0]         coef_reg;
  logic [COEF_WIDTH-1:0]         entry_reg [TABLE_SIZE];
  logic [BLOCK_WIDTH_INDEX_SIZE-1:0]  col_reg;
  logic [BLOCK_HEIGHT_INDEX_SIZE-1:0] row_reg;
  logic                          frame_done_reg, overflow_reg;

  logic                  accept, handoff, wr_en, ovf_set, frame_end;
  logic [COEF_WIDTH-1:0] coef_full, wr_val;
  logic [TGT_W-1:0]      target;

  assign accept    = is_new && (state_reg != S_HOLD);
  assign handoff   = (state_reg == S_HOLD) && table_ready;
  assign coef_full = COEF_WIDTH'({coef_reg, stream_bit});
  // Target index is computed one bit wider than pos so a long run cannot wrap.
  assign target    = TGT_W'(pos_reg) + TGT_W'(run_reg);
  assign frame_end = handoff
                  && (col_reg == BLOCK_WIDTH_INDEX_SIZE'(BLOCK_WIDTH_SIZE - 1))
                  && (row_reg == BLOCK_HEIGHT_INDEX_SIZE'(BLOCK_HEIGHT_SIZE - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pos_next   = pos_reg;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    case (state_reg)
      S_RUN: if (accept) begin
        if (cnt_reg == CNT_W'(RUN_WIDTH - 1)) begin
          cnt_next   = '0;
          state_next = S_COEF;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_COEF: if (accept) begin
        if (cnt_reg == CNT_W'(COEF_WIDTH - 1)) begin
          cnt_next = '0;
          // (0,0) at pos 0 is a zero DC, not an end-of-block marker.
          if (run_reg == '0 && coef_full == '0 && pos_reg != '0) begin
            state_next = S_HOLD;
          end else if (target < TGT_W'(TABLE_SIZE)) begin
            wr_en      = 1'b1;
            pos_next   = POS_W'(target + TGT_W'(1));
            state_next = (target == TGT_W'(TABLE_SIZE - 1)) ? S_HOLD : S_RUN;
          end else begin
            ovf_set    = 1'b1;
            state_next = S_HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HOLD: if (table_ready) begin
        state_next = S_RUN;
        pos_next   = '0;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_RUN;
      cnt_reg      <= '0;
      pos_reg      <= '0;
      run_reg      <= '0;
      coef_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pos_reg   <= pos_next;
      if (accept && state_reg == S_RUN)  run_reg  <= RUN_WIDTH'({run_reg, stream_bit});
      if (accept && state_reg == S_COEF) coef_reg <= coef_full;
      if (ovf_set) overflow_reg <= 1'b1;
    end
  end

`ifdef ASSEMBLER_DC_PREDICTION_EN
  logic [COEF_WIDTH-1:0] dc_pred_reg;

  always_ff @(posedge clk) begin
    if (rst || frame_end) dc_pred_reg <= '0;
    else if (handoff)     dc_pred_reg <= entry_reg[0];
  end

  assign wr_val = (target == '0) ? dc_pred_reg + coef_full : coef_full;
`else
  assign wr_val = coef_full;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < TABLE_SIZE; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst || handoff)                       entry_reg[gi] <= '0;
        else if (wr_en && target == TGT_W'(gi))   entry_reg[gi] <= wr_val;
      end
      assign table_value[gi*COEF_WIDTH +: COEF_WIDTH] = entry_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (handoff) begin
        if (col_reg == BLOCK_WIDTH_INDEX_SIZE'(BLOCK_WIDTH_SIZE - 1)) begin
          col_reg <= '0;
          row_reg <= (row_reg == BLOCK_HEIGHT_INDEX_SIZE'(BLOCK_HEIGHT_SIZE - 1)) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  assign bit_ready      = (state_reg != S_HOLD);
  assign table_valid    = (state_reg == S_HOLD);
  assign block_col      = col_reg;
  assign block_row      = row_reg;
  assign frame_done     = frame_done_reg;
  assign overflow_error = overflow_reg;
endmodule

// File: tb/tb_bitstream_block_assembler.sv
// Directed bench for bitstream_block_assembler: symbol parsing, backpressure, overflow, reset, frame walk.
module tb_bitstream_block_assembler;
  localparam int RW = 4, CW = 8, TS = 64, BW = 40, BH = 30, BWI = 6, BHI = 5;

  logic clk = 1'b0, rst = 1'b1, stream_bit = 1'b0, is_new = 1'b0, table_ready = 1'b1;
  logic bit_ready, table_valid, frame_done, overflow_error;
  logic [TS*CW-1:0] table_value, exp_tbl;
  logic [BWI-1:0] block_col;
  logic [BHI-1:0] block_row;
  int compared = 0, mismatched = 0;

  bitstream_block_assembler dut (
    .clk(clk), .rst(rst), .stream_bit(stream_bit), .is_new(is_new), .bit_ready(bit_ready),
    .table_value(table_value), .table_valid(table_valid), .table_ready(table_ready),
    .block_col(block_col), .block_row(block_row), .frame_done(frame_done),
    .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    int n = 0;
    stream_bit = b;
    is_new     = 1'b1;
    while (!bit_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bit_ready) begin
      compared++; mismatched++;
      $display("FAIL bit_ready_timeout: bit_ready=%0b required 1", bit_ready);
    end
    @(posedge clk); #1;
    is_new = 1'b0;
  endtask

  task automatic send_sym(input logic [RW-1:0] r, input logic [CW-1:0] c);
    for (int i = RW - 1; i >= 0; i--) send_bit(r[i]);
    for (int i = CW - 1; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    compared++;
    if (table_valid !== 1'b0 || bit_ready !== 1'b1 || frame_done !== 1'b0 || overflow_error !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: valid=%0b ready=%0b fd=%0b ovf=%0b required 0 1 0 0",
               table_valid, bit_ready, frame_done, overflow_error);
    end
    compared++;
    if (block_col !== '0 || block_row !== '0 || table_value !== '0) begin
      mismatched++;
      $display("FAIL reset_state: col=%0d row=%0d table_nonzero=%0b required 0 0 0",
               block_col, block_row, |table_value);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    table_ready = 1'b1;
    exp_tbl = '0;
    exp_tbl[0*CW +: CW] = 8'h05;
    exp_tbl[3*CW +: CW] = 8'hFD;
    send_sym(4'd0, 8'd5);
    send_sym(4'd2, 8'hFD);
    compared++;
    if (table_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_pre_valid: table_valid=%0b required 0", table_valid);
    end
    send_sym(4'd0, 8'd0);
    compared++;
    if (table_valid !== 1'b1 || bit_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_latency: valid=%0b ready=%0b required 1 0", table_valid, bit_ready);
    end
    compared++;
    if (table_value !== exp_tbl) begin
      mismatched++;
      $display("FAIL basic_table: got %h required %h", table_value, exp_tbl);
    end
    @(posedge clk); #1;
    compared++;
    if (table_valid !== 1'b0 || bit_ready !== 1'b1 || block_col !== BWI'(1)) begin
      mismatched++;
      $display("FAIL basic_handoff: valid=%0b ready=%0b col=%0d required 0 1 1",
               table_valid, bit_ready, block_col);
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure;
    logic hold_ok;
    logic [CW-1:0] k;
    table_ready = 1'b0;
    exp_tbl = '0;
    for (int i = 0; i < TS; i++) begin
      k = CW'(i + 1);
      exp_tbl[i*CW +: CW] = k;
      send_sym(4'd0, k);
    end
    compared++;
    if (table_valid !== 1'b1 || bit_ready !== 1'b0 || table_value !== exp_tbl) begin
      mismatched++;
      $display("FAIL bp_full_table: valid=%0b ready=%0b got %h required %h",
               table_valid, bit_ready, table_value, exp_tbl);
    end
    hold_ok = 1'b1;
    stream_bit = 1'b1;
    is_new = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (table_valid !== 1'b1 || bit_ready !== 1'b0 || table_value !== exp_tbl) hold_ok = 1'b0;
    end
    compared++;
    if (hold_ok !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_hold: hold_ok=%0b required 1", hold_ok);
    end
    is_new = 1'b0;
    table_ready = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (table_valid !== 1'b0 || block_col !== BWI'(2)) begin
      mismatched++;
      $display("FAIL bp_release: valid=%0b col=%0d required 0 2", table_valid, block_col);
    end
    exp_tbl = '0;
    exp_tbl[0*CW +: CW] = 8'd7;
    send_sym(4'd0, 8'd7);
    send_sym(4'd0, 8'd0);
    compared++;
    if (table_valid !== 1'b1 || table_value !== exp_tbl) begin
      mismatched++;
      $display("FAIL bp_no_consume: valid=%0b got %h required %h", table_valid, table_value, exp_tbl);
    end
    @(posedge clk); #1;
    $display("test_backpressure done");
  endtask

  task automatic test_overflow;
    table_ready = 1'b1;
    exp_tbl = '0;
    for (int i = 0; i < 60; i++) begin
      exp_tbl[i*CW +: CW] = 8'd1;
      send_sym(4'd0, 8'd1);
    end
    compared++;
    if (overflow_error !== 1'b0 || table_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_before: ovf=%0b valid=%0b required 0 0", overflow_error, table_valid);
    end
    send_sym(4'd15, 8'd1);
    compared++;
    if (overflow_error !== 1'b1 || table_valid !== 1'b1 || table_value !== exp_tbl) begin
      mismatched++;
      $display("FAIL ovf_symbol: ovf=%0b valid=%0b got %h required %h",
               overflow_error, table_valid, table_value, exp_tbl);
    end
    @(posedge clk); #1;
    exp_tbl = '0;
    exp_tbl[0*CW +: CW] = 8'd9;
    send_sym(4'd0, 8'd9);
    send_sym(4'd0, 8'd0);
    compared++;
    if (overflow_error !== 1'b1 || table_value !== exp_tbl) begin
      mismatched++;
      $display("FAIL ovf_sticky: ovf=%0b got %h required %h", overflow_error, table_value, exp_tbl);
    end
    @(posedge clk); #1;
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid_block;
    send_sym(4'd0, 8'd3);
    for (int i = 0; i < RW + 3; i++) send_bit(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if (table_valid !== 1'b0 || bit_ready !== 1'b1 || overflow_error !== 1'b0 || frame_done !== 1'b0
        || block_col !== '0 || block_row !== '0 || table_value !== '0) begin
      mismatched++;
      $display("FAIL midrst_outputs: valid=%0b ready=%0b ovf=%0b fd=%0b col=%0d row=%0d tbl_nz=%0b required 0 1 0 0 0 0 0",
               table_valid, bit_ready, overflow_error, frame_done, block_col, block_row, |table_value);
    end
    exp_tbl = '0;
    exp_tbl[0*CW +: CW] = 8'd4;
    exp_tbl[2*CW +: CW] = 8'd2;
    send_sym(4'd0, 8'd4);
    send_sym(4'd1, 8'd2);
    send_sym(4'd0, 8'd0);
    compared++;
    if (table_valid !== 1'b1 || table_value !== exp_tbl || block_col !== '0 || block_row !== '0) begin
      mismatched++;
      $display("FAIL midrst_redecode: valid=%0b col=%0d row=%0d got %h required %h",
               table_valid, block_col, block_row, table_value, exp_tbl);
    end
    @(posedge clk); #1;
    $display("test_reset_mid_block done");
  endtask

  task automatic test_frame;
    int fd_count = 0;
    logic [BWI-1:0] ec;
    logic [BHI-1:0] er;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    table_ready = 1'b1;
    for (int b = 0; b < BW * BH; b++) begin
      ec = BWI'(b % BW);
      er = BHI'(b / BW);
      send_sym(4'd0, 8'd0);
      send_sym(4'd0, 8'd0);
      compared++;
      if (table_valid !== 1'b1 || block_col !== ec || block_row !== er) begin
        mismatched++;
        $display("FAIL frame_pos: block %0d valid=%0b col=%0d row=%0d required 1 %0d %0d",
                 b, table_valid, block_col, block_row, ec, er);
      end
      @(posedge clk); #1;
      if (frame_done === 1'b1) fd_count++;
    end
    compared++;
    if (frame_done !== 1'b1 || block_col !== '0 || block_row !== '0) begin
      mismatched++;
      $display("FAIL frame_wrap: fd=%0b col=%0d row=%0d required 1 0 0", frame_done, block_col, block_row);
    end
    @(posedge clk); #1;
    compared++;
    if (frame_done !== 1'b0 || fd_count != 1) begin
      mismatched++;
      $display("FAIL frame_pulse: fd=%0b pulses=%0d required 0 1", frame_done, fd_count);
    end
    $display("test_frame done: %0d blocks, %0d frame_done pulses", BW * BH, fd_count);
  endtask

`ifdef ASSEMBLER_DC_PREDICTION_EN
  task automatic test_dc_prediction;
    logic [CW-1:0] diffs [3];
    logic [CW-1:0] exp_dc [3];
    diffs  = '{8'd10, 8'hFC, 8'd2};
    exp_dc = '{8'd10, 8'd6, 8'd8};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    table_ready = 1'b1;
    for (int b = 0; b < BW * BH; b++) begin
      send_sym(4'd0, (b < 3) ? diffs[b] : 8'd0);
      send_sym(4'd0, 8'd0);
      if (b < 3) begin
        compared++;
        if (table_value[CW-1:0] !== exp_dc[b]) begin
          mismatched++;
          $display("FAIL dc_pred: block %0d entry0=%0d required %0d", b, table_value[CW-1:0], exp_dc[b]);
        end
      end
      @(posedge clk); #1;
    end
    send_sym(4'd0, 8'd3);
    send_sym(4'd0, 8'd0);
    compared++;
    if (table_value[CW-1:0] !== 8'd3) begin
      mismatched++;
      $display("FAIL dc_frame_reset: entry0=%0d required 3", table_value[CW-1:0]);
    end
    @(posedge clk); #1;
    $display("test_dc_prediction done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid_block();
    test_frame();
`ifdef ASSEMBLER_DC_PREDICTION_EN
    test_dc_prediction();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
